// File: rtl/network_conv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : network_conv_pkg
// Description : Shared width constants and state encoding for the
//               convolution accumulator and its round/saturate stage.
// Revision    : 1.0 - initial release
// ============================================================================
package network_conv_pkg;

  // Default datapath widths (15s x 16s multiplier feeding a 3x3 window)
  localparam int CONV_PROD_WIDTH = 30;
  localparam int CONV_ACC_WIDTH  = 36;
  localparam int CONV_OUT_WIDTH  = 16;
  localparam int CONV_FRAC_SHIFT = 14;
  localparam int CONV_WIN_LEN    = 9;

  // Window accumulation state; "emit" happens on the closing beat itself,
  // so only two states are needed.
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } conv_state_e;

endpackage
`default_nettype wire

// File: rtl/network_conv_acc_round_sat.sv
`default_nettype none
// ============================================================================
// Module      : network_conv_acc_round_sat
// Description : Combinational round-half-up, arithmetic right shift,
//               saturation and optional ReLU from ACC_WIDTH to OUT_WIDTH.
// Ports       : i_acc  - signed accumulated sum
//               o_data - signed rounded/saturated result
//               o_sat  - result was clamped to an output limit
// Revision    : 1.0 - initial release
// ============================================================================
module network_conv_acc_round_sat #(
  parameter int ACC_WIDTH  = 36,
  parameter int OUT_WIDTH  = 16,
  parameter int FRAC_SHIFT = 14,
  parameter bit RELU_EN    = 1'b1
) (
  input  logic signed [ACC_WIDTH-1:0] i_acc,
  output logic signed [OUT_WIDTH-1:0] o_data,
  output logic                        o_sat
);

  localparam logic signed [ACC_WIDTH-1:0] c_half =
    {{(ACC_WIDTH-1){1'b0}}, 1'b1} << (FRAC_SHIFT-1);
  localparam logic signed [ACC_WIDTH-1:0] c_out_max =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] c_out_min =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  logic signed [ACC_WIDTH-1:0] w_rounded;
  logic signed [ACC_WIDTH-1:0] w_shifted;
  logic                        w_hi;
  logic                        w_lo;
  logic signed [OUT_WIDTH-1:0] w_clamped;

  assign w_rounded = i_acc + c_half;
  assign w_shifted = w_rounded >>> FRAC_SHIFT;
  assign w_hi      = (w_shifted > c_out_max);
  assign w_lo      = (w_shifted < c_out_min);

  always_comb begin
    w_clamped = w_shifted[OUT_WIDTH-1:0];
    if (w_hi) begin
      w_clamped = c_out_max[OUT_WIDTH-1:0];
    end else if (w_lo) begin
      w_clamped = c_out_min[OUT_WIDTH-1:0];
    end
  end

  // ReLU acts after saturation; the sat flag keeps reporting a negative clamp.
  assign o_data = (RELU_EN && w_clamped[OUT_WIDTH-1]) ? '0 : w_clamped;
  assign o_sat  = w_hi | w_lo;

endmodule
`default_nettype wire

// File: rtl/network_conv_acc.sv
`default_nettype none
// ============================================================================
// Module      : network_conv_acc
// Description : Accumulates one kernel window of signed products plus a
//               per-channel bias and emits one rounded, saturated (and
//               optionally ReLU'd) pixel per window on a valid/ready stream.
// Ports       : clk, reset (async, active-low)
//               prod_valid/prod_ready/prod_data/prod_last - product stream
//               bias      - per-channel bias, sampled on a window's first beat
//               out_valid/out_ready/out_data/out_sat      - result stream
//               len_err   - sticky window-length error, cleared by clr_err
// Revision    : 1.0 - initial release
// ============================================================================
module network_conv_acc
  import network_conv_pkg::*;
#(
  parameter int PROD_WIDTH = CONV_PROD_WIDTH,
  parameter int ACC_WIDTH  = CONV_ACC_WIDTH,
  parameter int OUT_WIDTH  = CONV_OUT_WIDTH,
  parameter int FRAC_SHIFT = CONV_FRAC_SHIFT,
  parameter int WIN_LEN    = CONV_WIN_LEN,
  parameter bit RELU_EN    = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         prod_valid,
  output logic                         prod_ready,
  input  logic signed [PROD_WIDTH-1:0] prod_data,
  input  logic                         prod_last,
  input  logic signed [OUT_WIDTH-1:0]  bias,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [OUT_WIDTH-1:0]  out_data,
  output logic                         out_sat,
  output logic                         len_err,
  input  logic                         clr_err
);

  localparam int                 c_cnt_w   = $clog2(WIN_LEN + 1);
  localparam logic [c_cnt_w-1:0] c_win_len = c_cnt_w'(WIN_LEN);

  // Elaboration-time guard on the width relationship; nothing is checked
  // at run time.
  if ((ACC_WIDTH < PROD_WIDTH + $clog2(WIN_LEN) + 1) ||
      (ACC_WIDTH < OUT_WIDTH + FRAC_SHIFT + 1) ||
      (FRAC_SHIFT < 1)) begin : g_param_err
    $error("network_conv_acc: ACC_WIDTH/FRAC_SHIFT parameters out of range");
  end

  conv_state_e                 r_state;
  logic signed [ACC_WIDTH-1:0] r_acc;
  logic [c_cnt_w-1:0]          r_cnt;
  logic                        r_out_valid;
  logic signed [OUT_WIDTH-1:0] r_out_data;
  logic                        r_out_sat;
  logic                        r_len_err;

  logic signed [ACC_WIDTH-1:0] w_prod_ext;
  logic signed [ACC_WIDTH-1:0] w_bias_ext;
  logic signed [ACC_WIDTH-1:0] w_acc_next;
  logic [c_cnt_w-1:0]          w_cnt_next;
  logic                        w_accept;
  logic                        w_full;
  logic                        w_close;
  logic                        w_mismatch;
  logic signed [OUT_WIDTH-1:0] w_rs_data;
  logic                        w_rs_sat;

  // Only registered terms: ready never depends on prod_valid.
  assign prod_ready = !r_out_valid || out_ready;
  assign w_accept   = prod_valid && prod_ready;

  assign w_prod_ext = {{(ACC_WIDTH-PROD_WIDTH){prod_data[PROD_WIDTH-1]}}, prod_data};
  // Bias is aligned to the product's fixed-point position (<< FRAC_SHIFT).
  assign w_bias_ext = {{(ACC_WIDTH-OUT_WIDTH-FRAC_SHIFT){bias[OUT_WIDTH-1]}},
                       bias, {FRAC_SHIFT{1'b0}}};

  assign w_acc_next = (r_state == ST_IDLE) ? (w_bias_ext + w_prod_ext)
                                           : (r_acc + w_prod_ext);
  assign w_cnt_next = (r_state == ST_IDLE) ? c_cnt_w'(1)
                                           : (r_cnt + c_cnt_w'(1));

  // A window closes on prod_last or on the WIN_LEN-th beat; disagreement
  // between the two is a length error but the result is still emitted.
  assign w_full     = (w_cnt_next == c_win_len);
  assign w_close    = w_accept && (prod_last || w_full);
  assign w_mismatch = w_accept && (prod_last != w_full);

  network_conv_acc_round_sat #(
    .ACC_WIDTH (ACC_WIDTH),
    .OUT_WIDTH (OUT_WIDTH),
    .FRAC_SHIFT(FRAC_SHIFT),
    .RELU_EN   (RELU_EN)
  ) u_round_sat (
    .i_acc (w_acc_next),
    .o_data(w_rs_data),
    .o_sat (w_rs_sat)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sat   <= 1'b0;
      r_len_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        if (w_close) begin
          r_state <= ST_IDLE;
          r_acc   <= '0;
          r_cnt   <= '0;
        end else begin
          r_state <= ST_ACCUM;
          r_acc   <= w_acc_next;
          r_cnt   <= w_cnt_next;
        end
      end

      // A close can only be accepted when the output slot is free or being
      // drained this cycle, so reloading here never drops a result.
      if (w_close) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_rs_data;
        r_out_sat   <= w_rs_sat;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end

      // A new error takes priority over a coincident clear.
      if (w_mismatch) begin
        r_len_err <= 1'b1;
      end else if (clr_err) begin
        r_len_err <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sat   = r_out_sat;
  assign len_err   = r_len_err;

endmodule
`default_nettype wire

// File: tb/tb_network_conv_acc.sv
`default_nettype none
// ============================================================================
// Module      : tb_network_conv_acc
// Description : Self-checking bench for network_conv_acc. Two instances
//               (RELU off / RELU on) share one stimulus stream; expected
//               results are queued when a window closes and compared when
//               the output handshake completes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_network_conv_acc;

  typedef struct packed {
    logic signed [15:0] d0;   // RELU_EN = 0 result
    logic signed [15:0] d1;   // RELU_EN = 1 result
    logic               sat;
  } exp_t;

  logic               clk;
  logic               reset;
  logic               prod_valid;
  logic               prod_ready;
  logic               prod_ready1;
  logic signed [29:0] prod_data;
  logic               prod_last;
  logic signed [15:0] bias;
  logic               out_valid0, out_valid1;
  logic               out_ready;
  logic signed [15:0] out_data0, out_data1;
  logic               out_sat0, out_sat1;
  logic               len_err, len_err1;
  logic               clr_err;

  int     checks = 0;
  int     errors = 0;
  int     cyc    = 0;
  exp_t   sb[$];
  longint m_sum;
  int     m_cnt;
  bit     m_idle;
  bit     m_len_err;

  network_conv_acc #(.RELU_EN(1'b0)) u_dut0 (
    .clk(clk), .reset(reset),
    .prod_valid(prod_valid), .prod_ready(prod_ready),
    .prod_data(prod_data), .prod_last(prod_last), .bias(bias),
    .out_valid(out_valid0), .out_ready(out_ready),
    .out_data(out_data0), .out_sat(out_sat0),
    .len_err(len_err), .clr_err(clr_err)
  );

  network_conv_acc #(.RELU_EN(1'b1)) u_dut1 (
    .clk(clk), .reset(reset),
    .prod_valid(prod_valid), .prod_ready(prod_ready1),
    .prod_data(prod_data), .prod_last(prod_last), .bias(bias),
    .out_valid(out_valid1), .out_ready(out_ready),
    .out_data(out_data1), .out_sat(out_sat1),
    .len_err(len_err1), .clr_err(clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input longint sum);
    exp_t   e;
    longint r;
    r     = (sum + 64'sd8192) >>> 14;
    e.sat = (r > 32767) || (r < -32768);
    if (r > 32767)       r = 32767;
    else if (r < -32768) r = -32768;
    e.d0 = 16'(r);
    e.d1 = (r < 0) ? 16'sd0 : 16'(r);
    return e;
  endfunction

  // Scoreboard consumer: a transfer happens at the next posedge.
  always @(negedge clk) begin
    if (reset === 1'b1 && out_valid0 === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_output", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_data_relu0", out_data0, e.d0);
        check("out_data_relu1", out_data1, e.d1);
        check("out_sat_relu0", out_sat0, e.sat);
        check("out_sat_relu1", out_sat1, e.sat);
        check("out_valid_relu1", out_valid1, 1);
      end
    end
  end

  // Drive one beat, wait (bounded) for acceptance, then update the model.
  task automatic send_beat(input logic signed [29:0] d, input logic l,
                           input logic signed [15:0] b);
    logic rdy;
    int   waited;
    bit   close;
    waited     = 0;
    prod_valid = 1'b1;
    prod_data  = d;
    prod_last  = l;
    bias       = b;
    do begin
      @(negedge clk);
      rdy = prod_ready;
      @(posedge clk);
      #1;
      waited++;
    end while (rdy !== 1'b1 && waited < 50);
    prod_valid = 1'b0;
    prod_last  = 1'b0;
    if (rdy !== 1'b1) begin
      check("beat_accept_timeout", 0, 1);
      return;
    end
    if (m_idle) begin
      m_sum = longint'(b) * 16384 + longint'(d);
      m_cnt = 1;
    end else begin
      m_sum = m_sum + longint'(d);
      m_cnt = m_cnt + 1;
    end
    close = l || (m_cnt == 9);
    if (l != (m_cnt == 9)) m_len_err = 1'b1;
    if (close) begin
      sb.push_back(model(m_sum));
      m_idle = 1'b1;
      check("close_latency_valid", out_valid0, 1);
    end else begin
      m_idle = 1'b0;
    end
  endtask

  task automatic send_window(input int n, input int last_at,
                             input logic signed [29:0] d,
                             input logic signed [15:0] b);
    for (int i = 1; i <= n; i++) send_beat(d, (i == last_at), b);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 30) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_queue_empty", sb.size(), 0);
  endtask

  initial begin
    int t0;
    reset      = 1'b1;
    prod_valid = 1'b0;
    prod_data  = '0;
    prod_last  = 1'b0;
    bias       = '0;
    out_ready  = 1'b1;
    clr_err    = 1'b0;
    m_idle     = 1'b1;
    m_len_err  = 1'b0;
    m_sum      = 0;
    m_cnt      = 0;

    // Reset state
    #2 reset = 1'b0;
    #1;
    check("rst_out_valid", out_valid0, 0);
    check("rst_out_data", out_data0, 0);
    check("rst_out_sat", out_sat0, 0);
    check("rst_len_err", len_err, 0);
    check("rst_prod_ready", prod_ready, 1);
    @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk);
    #1;

    // Unity sum, back-to-back beats
    t0 = cyc;
    send_window(9, 9, 30'sd16384, 16'sd0);
    check("unity_throughput_cycles", cyc - t0, 9);
    drain();
    check("unity_len_err", len_err, m_len_err);

    // Rounding
    send_beat(30'sd8192, 1'b0, 16'sd0);  send_window(8, 8, 30'sd0, 16'sd0);
    send_beat(-30'sd8192, 1'b0, 16'sd0); send_window(8, 8, 30'sd0, 16'sd0);
    send_beat(-30'sd8193, 1'b0, 16'sd0); send_window(8, 8, 30'sd0, 16'sd0);
    drain();

    // Bias and saturation
    send_window(9, 9, 30'sd0, 16'sd5);
    send_window(9, 9, 30'sd268435456, 16'sd0);
    send_window(9, 9, -30'sd268435456, 16'sd0);
    send_window(9, 9, 30'sd3000, -16'sd7);
    drain();
    check("no_len_err_yet", len_err, 0);

    // Backpressure: second window stalls until the first result leaves
    out_ready = 1'b0;
    send_window(9, 9, 30'sd16384, 16'sd0);
    fork
      send_window(9, 9, 30'sd32768, 16'sd0);
      begin
        repeat (4) begin
          @(negedge clk);
          check("bp_prod_ready_low", prod_ready, 0);
          check("bp_out_valid_held", out_valid0, 1);
          check("bp_out_data_held", out_data0, 9);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Length errors: early last, then nine beats with no last
    send_window(4, 4, 30'sd16384, 16'sd0);
    check("early_last_len_err", len_err, 1);
    send_window(9, 0, 30'sd16384, 16'sd1);
    drain();
    check("no_last_len_err", len_err, m_len_err);

    clr_err = 1'b1;
    @(posedge clk);
    #1 clr_err = 1'b0;
    m_len_err = 1'b0;
    check("clr_err_clears", len_err, 0);

    // Clear coinciding with a new error, and back-to-back closes
    clr_err = 1'b1;
    send_beat(30'sd0, 1'b1, 16'sd3);
    clr_err = 1'b0;
    send_beat(30'sd0, 1'b1, 16'sd4);
    check("error_beats_clear", len_err, 1);
    drain();
    check("held_data_before_reset", out_data0, 4);

    // Asynchronous reset mid-window
    send_window(5, 0, 30'sd16384, 16'sd2);
    #2 reset = 1'b0;
    #1;
    check("async_rst_out_valid", out_valid0, 0);
    check("async_rst_out_data", out_data0, 0);
    check("async_rst_len_err", len_err, 0);
    check("async_rst_prod_ready", prod_ready, 1);
    m_idle    = 1'b1;
    m_len_err = 1'b0;
    @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk);
    #1;
    send_window(9, 9, 30'sd16384, 16'sd0);
    drain();
    check("post_reset_len_err", len_err, 0);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/network_conv_acc.md
Name: network_conv_acc

Overview:
- Downstream consumer of the 15s x 16s -> 30-bit pipelined multiplier in the convolution datapath.
- Accumulates one kernel window of signed products, adds a per-channel bias, and produces one output pixel per window.
- Output is rounded, shifted, saturated and optionally ReLU'd to a 16-bit fixed-point value.
- Results go out on a valid/ready stream to the next layer / line buffer.

Parameters:
- PROD_WIDTH, 30, signed product width from the multiplier.
- ACC_WIDTH, 36, signed accumulator width; must be >= PROD_WIDTH + clog2(WIN_LEN) + 1 and >= OUT_WIDTH + FRAC_SHIFT + 1.
- OUT_WIDTH, 16, signed output width.
- FRAC_SHIFT, 14, right-shift applied to the accumulated sum; must be >= 1.
- WIN_LEN, 9, number of products per window (3x3 kernel).
- RELU_EN, 1, 1 = clamp negative results to 0.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- prod_valid  in  1  product beat valid.
- prod_ready  out  1  block accepts a beat.
- prod_data  in  PROD_WIDTH  signed product.
- prod_last  in  1  last product of the window.
- bias  in  OUT_WIDTH  signed bias; sampled on the first beat of each window.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- out_data  out  OUT_WIDTH  signed result.
- out_sat  out  1  result was saturated; qualified by out_valid.
- len_err  out  1  sticky window-length error.
- clr_err  in  1  synchronous pulse; clears len_err.

Behaviour:
- Reset (reset=0, async): acc=0, term_cnt=0, state=IDLE, out_valid=0, out_data=0, out_sat=0, len_err=0. A reset mid-window discards the partial sum with no output.
- Handshake:
  - Beat accepted when prod_valid && prod_ready.
  - prod_ready = !out_valid || out_ready; registered terms only, no dependency on prod_valid.
  - Output held stable while out_valid && !out_ready.
- States:
  - IDLE: no partial sum. An accepted beat loads acc = sext(bias) << FRAC_SHIFT + sext(prod_data), sets term_cnt=1, and goes to ACCUM. If that beat closes the window, it goes to EMIT instead.
  - ACCUM: each accepted beat does acc += sext(prod_data) and term_cnt++.
  - EMIT (window closes): acc_final feeds the output register in the same cycle as the closing beat; state returns to IDLE. The next beat is accepted the following cycle if prod_ready.
- Window close:
  - Close on the beat where prod_last=1, or on the beat where term_cnt reaches WIN_LEN.
  - Mismatch between the two (last early, or WIN_LEN reached without last) sets len_err=1. The result is still emitted.
- Output arithmetic:
  - r = (acc_final + 2^(FRAC_SHIFT-1)) >>> FRAC_SHIFT, arithmetic shift (round half up).
  - If r > 2^(OUT_WIDTH-1)-1 or r < -2^(OUT_WIDTH-1): clamp to the limit and set out_sat=1.
  - Then if RELU_EN and r<0: r=0. out_sat stays as computed; a negative saturation still flags.
- Latency: out_valid rises on the cycle after the closing beat is accepted. Sustained throughput is 1 beat/clock when out_ready=1.
- Simultaneous events:
  - Output accepted and a new window close in the same cycle: the output register reloads; out_valid stays 1.
  - clr_err coinciding with a new error: the error wins (len_err=1).
- No intermediate overflow is possible within the ACC_WIDTH constraint. The block does not check the constraint at runtime; the parameter assertion is for simulation only.

Decomposition:
- Shared package network_conv_pkg:
  - width constants PROD_WIDTH, ACC_WIDTH, OUT_WIDTH, FRAC_SHIFT, WIN_LEN.
  - state enum {IDLE, ACCUM}.
- One sub-module: network_conv_acc_round_sat, combinational round/shift/saturate/ReLU from ACC_WIDTH to OUT_WIDTH, plus the sat flag. It is reused by the pooling stage.

Test Plan:
- Unity sum: bias=0, nine beats prod_data=16384, last on 9th -> out_data=9 (147456+8192>>14), out_sat=0, len_err=0, out_valid 1 cycle after 9th beat.
- Rounding: bias=0, one beat 8192 plus eight 0 -> out_data=1. Repeat with -8192 -> 0; with -8193 and RELU_EN=0 -> -1; same with RELU_EN=1 -> 0.
- Bias and saturation: bias=5 with nine zeros -> out_data=5. bias=0 with nine beats 2^28 -> out_data=32767, out_sat=1. Nine beats -2^28 with RELU_EN=0 -> -32768, out_sat=1.
- Backpressure: out_ready=0 while two windows are streamed -> prod_ready drops after the first result. The first result is held stable; the second completes only after out_ready=1. No beat is lost and results arrive in order.
- Length error: prod_last on the 4th beat -> result of 4 terms is emitted, len_err=1. A following window of nine beats with no last closes at the 9th beat. A clr_err pulse clears len_err.
- Async reset: assert reset=0 mid-window (after 5 beats) -> all outputs 0 immediately. After release, a full window of 16384s -> out_data=9, with no residue from before the reset.
